ahmes_control_unit: RTL and testbench

//  Multicycle fetch/decode/execute sequencer for the Ahmes 8-bit CPU.
//  - Drives datapath strobes: PC, REM, RDM, RI, AC, memory and ALU op.
//  - Owns load_flags_en of status_register; reads back N,Z,C,B,V to resolve conditional jumps.
//  - One instruction in flight, no pipelining; halts on HLT until reset.

---
 rtl/ahmes_pkg.sv | 89 ++++++++
 rtl/ahmes_branch_cond.sv | 47 ++++
 rtl/ahmes_control_unit.sv | 171 +++++++++++++++++
 tb/tb_ahmes_control_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ahmes_pkg.sv
// Shared definitions for the Ahmes control unit: opcode groups, ALU operation
// encoding, sequencer states and the bundle of datapath strobes.
package ahmes_pkg;

  // Instruction groups, taken from opcode[7:4]
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_STA   = 4'h1;
  localparam logic [3:0] OP_LDA   = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_SUB   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JN    = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_JC    = 4'hB;
  localparam logic [3:0] OP_SHIFT = 4'hE;
  localparam logic [3:0] OP_HLT   = 4'hF;

  // Jump subcodes, taken from opcode[3:2]
  localparam logic [1:0] JSUB_N  = 2'b00;
  localparam logic [1:0] JSUB_P  = 2'b01;
  localparam logic [1:0] JSUB_V  = 2'b10;
  localparam logic [1:0] JSUB_NV = 2'b11;
  localparam logic [1:0] JSUB_C  = 2'b00;
  localparam logic [1:0] JSUB_NC = 2'b01;
  localparam logic [1:0] JSUB_B  = 2'b10;
  localparam logic [1:0] JSUB_NB = 2'b11;

  typedef enum logic [3:0] {
    ALU_PASS_B = 4'd0,
    ALU_ADD    = 4'd1,
    ALU_SUB    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_AND    = 4'd4,
    ALU_NOT    = 4'd5,
    ALU_SHR    = 4'd6,
    ALU_SHL    = 4'd7,
    ALU_ROR    = 4'd8,
    ALU_ROL    = 4'd9
  } alu_op_t;

  typedef enum logic [3:0] {
    S_F0, S_F1, S_F2, S_F3,
    S_DEC,
    S_A0, S_A1, S_A2,
    S_J,
    S_M0, S_M1, S_M2,
    S_EX,
    S_HALT
  } ctrl_state_t;

  typedef struct packed {
    logic    pc_load;
    logic    pc_inc;
    logic    rem_load;
    logic    rem_sel;
    logic    mem_rd;
    logic    mem_we;
    logic    rdm_load;
    logic    ri_load;
    logic    ac_load;
    logic    load_flags_en;
    alu_op_t alu_op;
    logic    halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic is_jump(input logic [3:0] op_hi);
    return op_hi inside {OP_JMP, OP_JN, OP_JZ, OP_JC};
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op_hi);
    return op_hi inside {OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_SUB};
  endfunction

  function automatic alu_op_t mem_alu_op(input logic [3:0] op_hi);
    case (op_hi)
      OP_ADD:  return ALU_ADD;
      OP_OR:   return ALU_OR;
      OP_AND:  return ALU_AND;
      OP_SUB:  return ALU_SUB;
      default: return ALU_PASS_B;
    endcase
  endfunction

endpackage

// File: rtl/ahmes_branch_cond.sv
// Resolves whether a conditional jump is taken from opcode[7:2] and the
// status flags; non-jump opcodes always yield "not taken".
module ahmes_branch_cond
  import ahmes_pkg::*;
(
  input  logic [5:0] opcode_hi,
  input  logic       n,
  input  logic       z,
  input  logic       c,
  input  logic       b,
  input  logic       v,
  output logic       take
);

  logic [3:0] grp;
  logic [1:0] sub;

  assign grp = opcode_hi[5:2];
  assign sub = opcode_hi[1:0];

  always_comb begin
    take = 1'b0;
    case (grp)
      OP_JMP: take = 1'b1;
      OP_JN: begin
        case (sub)
          JSUB_N:  take = n;
          JSUB_P:  take = !n;
          JSUB_V:  take = v;
          JSUB_NV: take = !v;
        endcase
      end
      // JZ/JNZ: subcode bit 0 inverts the sense
      OP_JZ: take = z ^ sub[0];
      OP_JC: begin
        case (sub)
          JSUB_C:  take = c;
          JSUB_NC: take = !c;
          JSUB_B:  take = b;
          JSUB_NB: take = !b;
        endcase
      end
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/ahmes_control_unit.sv
// Multicycle fetch/decode/execute sequencer for the Ahmes 8-bit CPU; drives
// the datapath strobes and owns the status register's flag-load enable.
module ahmes_control_unit
  import ahmes_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] ri_opcode,
  input  logic       n,
  input  logic       z,
  input  logic       c,
  input  logic       b,
  input  logic       v,
  output logic       pc_load,
  output logic       pc_inc,
  output logic       rem_load,
  output logic       rem_sel,
  output logic       mem_rd,
  output logic       mem_we,
  output logic       rdm_load,
  output logic       ri_load,
  output logic       ac_load,
  output logic [3:0] alu_op,
  output logic       load_flags_en,
  output logic       halted
);

  generate
    if (MEM_LAT != 1) begin : g_bad_mem_lat
      $error("ahmes_control_unit: only MEM_LAT = 1 is supported");
    end
  endgenerate

  ctrl_state_t state, state_next;
  ctrl_t       ctrl, ctrl_out;
  logic [3:0]  op_hi;
  logic        take;

  assign op_hi = ri_opcode[7:4];

  ahmes_branch_cond u_branch_cond (
    .opcode_hi (ri_opcode[7:2]),
    .n         (n),
    .z         (z),
    .c         (c),
    .b         (b),
    .v         (v),
    .take      (take)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_F0;
    else          state <= state_next;
  end

  always_comb begin
    // NOTE: every output and the next state get a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    ctrl       = CTRL_IDLE;
    state_next = state;
    case (state)
      S_F0: begin
        ctrl.rem_load = 1'b1;
        state_next    = S_F1;
      end
      S_F1: begin
        ctrl.mem_rd = 1'b1;
        ctrl.pc_inc = 1'b1;
        state_next  = S_F2;
      end
      S_F2: begin
        ctrl.rdm_load = 1'b1;
        state_next    = S_F3;
      end
      S_F3: begin
        ctrl.ri_load = 1'b1;
        state_next   = S_DEC;
      end
      S_DEC: begin
        state_next = S_F0;
        if (op_hi == OP_NOT) begin
          ctrl.ac_load       = 1'b1;
          ctrl.load_flags_en = 1'b1;
          ctrl.alu_op        = ALU_NOT;
        end else if (op_hi == OP_SHIFT && ri_opcode[3:2] == 2'b00) begin
          ctrl.ac_load       = 1'b1;
          ctrl.load_flags_en = 1'b1;
          case (ri_opcode[1:0])
            2'd0: ctrl.alu_op = ALU_SHR;
            2'd1: ctrl.alu_op = ALU_SHL;
            2'd2: ctrl.alu_op = ALU_ROR;
            2'd3: ctrl.alu_op = ALU_ROL;
          endcase
        end else if (op_hi == OP_HLT) begin
          state_next = S_HALT;
        end else if (is_jump(op_hi) || is_mem_op(op_hi)) begin
          state_next = S_A0;
        end
      end
      S_A0: begin
        ctrl.rem_load = 1'b1;
        state_next    = S_A1;
      end
      S_A1: begin
        ctrl.mem_rd = 1'b1;
        ctrl.pc_inc = 1'b1;
        state_next  = S_A2;
      end
      S_A2: begin
        ctrl.rdm_load = 1'b1;
        state_next    = is_jump(op_hi) ? S_J : S_M0;
      end
      // A jump not taken needs no PC strobe: PC already skipped the operand
      S_J: begin
        ctrl.pc_load = take;
        state_next   = S_F0;
      end
      S_M0: begin
        ctrl.rem_load = 1'b1;
        ctrl.rem_sel  = 1'b1;
        state_next    = S_M1;
      end
      S_M1: begin
        if (op_hi == OP_STA) begin
          ctrl.mem_we = 1'b1;
          state_next  = S_F0;
        end else begin
          ctrl.mem_rd = 1'b1;
          state_next  = S_M2;
        end
      end
      S_M2: begin
        ctrl.rdm_load = 1'b1;
        state_next    = S_EX;
      end
      S_EX: begin
        ctrl.ac_load       = 1'b1;
        ctrl.load_flags_en = 1'b1;
        ctrl.alu_op        = mem_alu_op(op_hi);
        state_next         = S_F0;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
        state_next  = S_HALT;
      end
      default: state_next = S_F0;
    endcase
  end

  // Strobes are held idle while reset is asserted, so an aborted instruction
  // cannot complete a write in the reset cycle.
  assign ctrl_out = reset_n ? ctrl : CTRL_IDLE;

  assign pc_load       = ctrl_out.pc_load;
  assign pc_inc        = ctrl_out.pc_inc;
  assign rem_load      = ctrl_out.rem_load;
  assign rem_sel       = ctrl_out.rem_sel;
  assign mem_rd        = ctrl_out.mem_rd;
  assign mem_we        = ctrl_out.mem_we;
  assign rdm_load      = ctrl_out.rdm_load;
  assign ri_load       = ctrl_out.ri_load;
  assign ac_load       = ctrl_out.ac_load;
  assign alu_op        = ctrl_out.alu_op;
  assign load_flags_en = ctrl_out.load_flags_en;
  assign halted        = ctrl_out.halted;

endmodule

// File: tb/tb_ahmes_control_unit.sv
// Self-checking bench for ahmes_control_unit: per-instruction strobe traces
// from a table-driven reference model, directed cases plus random programs.
module tb_ahmes_control_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] ri_opcode;
  logic       n, z, c, b, v;
  logic       pc_load, pc_inc, rem_load, rem_sel, mem_rd, mem_we;
  logic       rdm_load, ri_load, ac_load, load_flags_en, halted;
  logic [3:0] alu_op;

  always #5 clk = ~clk;

  ahmes_control_unit #(.MEM_LAT(1)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ri_opcode     (ri_opcode),
    .n             (n),
    .z             (z),
    .c             (c),
    .b             (b),
    .v             (v),
    .pc_load       (pc_load),
    .pc_inc        (pc_inc),
    .rem_load      (rem_load),
    .rem_sel       (rem_sel),
    .mem_rd        (mem_rd),
    .mem_we        (mem_we),
    .rdm_load      (rdm_load),
    .ri_load       (ri_load),
    .ac_load       (ac_load),
    .alu_op        (alu_op),
    .load_flags_en (load_flags_en),
    .halted        (halted)
  );

  // Observed strobe word: {pc_load, pc_inc, rem_load, rem_sel, mem_rd, mem_we,
  // rdm_load, ri_load, ac_load, load_flags_en, alu_op[3:0], halted}
  logic [14:0] obs;
  assign obs = {pc_load, pc_inc, rem_load, rem_sel, mem_rd, mem_we,
                rdm_load, ri_load, ac_load, load_flags_en, alu_op, halted};

  localparam logic [14:0] E_IDLE    = 15'h0000;
  localparam logic [14:0] E_PC_LOAD = 15'h4000;
  localparam logic [14:0] E_PC_INC  = 15'h2000;
  localparam logic [14:0] E_REM     = 15'h1000;
  localparam logic [14:0] E_REM_SEL = 15'h0800;
  localparam logic [14:0] E_MEM_RD  = 15'h0400;
  localparam logic [14:0] E_MEM_WE  = 15'h0200;
  localparam logic [14:0] E_RDM     = 15'h0100;
  localparam logic [14:0] E_RI      = 15'h0080;
  localparam logic [14:0] E_AC      = 15'h0040;
  localparam logic [14:0] E_FLAGS   = 15'h0020;
  localparam logic [14:0] E_HALTED  = 15'h0001;

  // ALU codes in the order the operation list defines them
  localparam int A_PASS_B = 0, A_ADD = 1, A_SUB = 2, A_OR = 3, A_AND = 4;
  localparam int A_NOT = 5, A_SHR = 6;

  localparam int HALT_CYCLES = 50;

  int vectors     = 0;
  int miscompares = 0;

  logic [14:0] exp_q[$];

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [14:0] alu_ev(input int code);
    return E_AC | E_FLAGS | (15'(code) << 1);
  endfunction

  function automatic bit jump_taken(input logic [7:0] op, input logic [4:0] f);
    // f = {n, z, c, b, v}
    case (op)
      8'h80:   return 1'b1;
      8'h90:   return f[4];
      8'h94:   return !f[4];
      8'h98:   return f[0];
      8'h9C:   return !f[0];
      8'hA0:   return f[3];
      8'hA4:   return !f[3];
      8'hB0:   return f[2];
      8'hB4:   return !f[2];
      8'hB8:   return f[1];
      8'hBC:   return !f[1];
      default: return 1'b0;
    endcase
  endfunction

  // Expected strobe word for every cycle of one instruction, starting at its fetch
  function automatic void build_trace(input logic [7:0] op, input logic [4:0] f);
    exp_q.delete();
    exp_q.push_back(E_REM);
    exp_q.push_back(E_MEM_RD | E_PC_INC);
    exp_q.push_back(E_RDM);
    exp_q.push_back(E_RI);
    case (op)
      8'h60: exp_q.push_back(alu_ev(A_NOT));
      8'hE0, 8'hE1, 8'hE2, 8'hE3: exp_q.push_back(alu_ev(A_SHR + int'(op - 8'hE0)));
      8'hF0: begin
        exp_q.push_back(E_IDLE);
        for (int i = 0; i < HALT_CYCLES; i++) exp_q.push_back(E_HALTED);
      end
      8'h80, 8'h90, 8'h94, 8'h98, 8'h9C, 8'hA0, 8'hA4,
      8'hB0, 8'hB4, 8'hB8, 8'hBC: begin
        exp_q.push_back(E_IDLE);
        exp_q.push_back(E_REM);
        exp_q.push_back(E_MEM_RD | E_PC_INC);
        exp_q.push_back(E_RDM);
        exp_q.push_back(jump_taken(op, f) ? E_PC_LOAD : E_IDLE);
      end
      8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h70: begin
        exp_q.push_back(E_IDLE);
        exp_q.push_back(E_REM);
        exp_q.push_back(E_MEM_RD | E_PC_INC);
        exp_q.push_back(E_RDM);
        exp_q.push_back(E_REM | E_REM_SEL);
        if (op == 8'h10) begin
          exp_q.push_back(E_MEM_WE);
        end else begin
          exp_q.push_back(E_MEM_RD);
          exp_q.push_back(E_RDM);
          case (op)
            8'h30:   exp_q.push_back(alu_ev(A_ADD));
            8'h40:   exp_q.push_back(alu_ev(A_OR));
            8'h50:   exp_q.push_back(alu_ev(A_AND));
            8'h70:   exp_q.push_back(alu_ev(A_SUB));
            default: exp_q.push_back(alu_ev(A_PASS_B));
          endcase
        end
      end
      default: exp_q.push_back(E_IDLE);  // NOP and undefined opcodes
    endcase
  endfunction

  // Called just after a falling edge with the DUT at the start of a fetch
  task automatic run_instr(input logic [7:0] op, input logic [4:0] f, input int stop_at);
    ri_opcode = op;
    {n, z, c, b, v} = f;
    build_trace(op, f);
    for (int i = 0; i < exp_q.size() && i < stop_at; i++) begin
      #1;
      check($sformatf("op%h_f%b_cyc%0d", op, f, i), obs, exp_q[i]);
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check(tag, obs, E_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [7:0] ops[] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70,
                        8'h80, 8'h90, 8'h94, 8'h98, 8'h9C, 8'hA0, 8'hA4,
                        8'hB0, 8'hB4, 8'hB8, 8'hBC, 8'hE0, 8'hE1, 8'hE2, 8'hE3,
                        8'hC0, 8'hD7, 8'hE4, 8'hE9, 8'hEF};

  initial begin
    reset_n   = 1'b0;
    ri_opcode = 8'h00;
    {n, z, c, b, v} = 5'b0;

    // Two reset cycles with every strobe low, then fetch starts immediately
    @(negedge clk);
    #1 check("reset_cyc0", obs, E_IDLE);
    @(negedge clk);
    #1 check("reset_cyc1", obs, E_IDLE);
    reset_n = 1'b1;

    run_instr(8'h30, 5'b00000, 1000);  // ADD
    run_instr(8'hA0, 5'b01000, 1000);  // JZ taken
    run_instr(8'hA0, 5'b10111, 1000);  // JZ not taken
    run_instr(8'h10, 5'b11111, 1000);  // STA
    run_instr(8'h60, 5'b00000, 1000);  // NOT
    run_instr(8'hE3, 5'b00000, 1000);  // ROL
    run_instr(8'h80, 5'b00000, 1000);  // JMP
    run_instr(8'hBC, 5'b00000, 1000);  // JNB taken
    run_instr(8'hEC, 5'b00000, 1000);  // undefined -> NOP

    // Reset in S_M1 of LDA: no write strobes, restart at fetch
    run_instr(8'h20, 5'b00000, 9);
    pulse_reset("lda_abort");
    run_instr(8'h20, 5'b00000, 1000);

    for (int k = 0; k < 150; k++) begin
      run_instr(ops[$urandom_range(0, ops.size() - 1)], 5'($urandom), 1000);
    end

    // HLT stays halted with idle strobes; reset releases it
    run_instr(8'hF0, 5'b00000, 1000);
    pulse_reset("halt_reset");
    run_instr(8'h00, 5'b00000, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
